// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types: RAM handshake state plus arbiter grant kinds and FSM states.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {NONE, IREAD, DREAD, DWRITE} arb_kind_t;
    typedef enum logic {IDLE, GRANT} arb_state_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin first-set finder: first req bit at or after ptr, wrapping.
module rr_picker #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          valid
);
    int j;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = j[PW-1:0];
            end
        end
    end
endmodule

// File: rtl/memory_arbiter_rr.sv
// Round-robin arbiter putting CPUS cores (I and D port each) onto one RAM port.
// Grant is registered in IDLE and held until ACCESS, withdrawal or the ERROR limit.
module memory_arbiter_rr
    import cpu_types_pkg::*;
#(
    parameter int CPUS      = 2,
    parameter int WORD_W    = 32,
    parameter int ERR_RETRY = 4
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS*WORD_W-1:0]   iaddr,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS*WORD_W-1:0]   daddr,
    input  logic [CPUS*WORD_W-1:0]   dstore,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS*WORD_W-1:0]   iload,
    output logic [CPUS*WORD_W-1:0]   dload,
    output logic [CPUS-1:0]          derr,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [WORD_W-1:0]        ramaddr,
    output logic [WORD_W-1:0]        ramstore,
    input  logic [WORD_W-1:0]        ramload,
    input  ramstate_t                ramstate
);
    localparam int PW = ptr_w(CPUS);
    localparam int EW = $clog2(ERR_RETRY + 1);

    arb_state_t      state_q, state_d;
    arb_kind_t       gnt_kind_q, gnt_kind_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d, gnt_cpu_q, gnt_cpu_d, pick_idx, next_ptr;
    logic [EW-1:0]   err_cnt_q, err_cnt_d;
    logic [CPUS-1:0] derr_q, derr_d, req;
    logic            pick_valid, live, active, done;

    assign req = dREN | dWEN | iREN;

    rr_picker #(.N(CPUS), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // The grant only stays meaningful while the granted enable is still held.
    always_comb begin
        case (gnt_kind_q)
            DREAD:   live = dREN[gnt_cpu_q];
            DWRITE:  live = dWEN[gnt_cpu_q];
            IREAD:   live = iREN[gnt_cpu_q];
            default: live = 1'b0;
        endcase
    end

    assign active   = (state_q == GRANT) && live;
    assign done     = active && (ramstate == ACCESS);
    assign next_ptr = (gnt_cpu_q == PW'(CPUS - 1)) ? '0 : gnt_cpu_q + 1'b1;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            gnt_kind_q <= NONE;
            rr_ptr_q   <= '0;
            gnt_cpu_q  <= '0;
            err_cnt_q  <= '0;
            derr_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_kind_q <= gnt_kind_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_cpu_q  <= gnt_cpu_d;
            err_cnt_q  <= err_cnt_d;
            derr_q     <= derr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_kind_d = gnt_kind_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_cpu_d  = gnt_cpu_q;
        err_cnt_d  = err_cnt_q;
        derr_d     = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d   = GRANT;
                    gnt_cpu_d = pick_idx;
                    err_cnt_d = '0;
                    if (dREN[pick_idx])      gnt_kind_d = DREAD;
                    else if (dWEN[pick_idx]) gnt_kind_d = DWRITE;
                    else                     gnt_kind_d = IREAD;
                end
            end
            GRANT: begin
                if (!live) begin
                    state_d    = IDLE;
                    gnt_kind_d = NONE;
                end else if (ramstate == ACCESS) begin
                    state_d    = IDLE;
                    gnt_kind_d = NONE;
                    rr_ptr_d   = next_ptr;
                end else if (ramstate == ERROR) begin
                    if (err_cnt_q == EW'(ERR_RETRY - 1)) begin
                        state_d    = IDLE;
                        gnt_kind_d = NONE;
                        rr_ptr_d   = next_ptr;
                        if (gnt_kind_q != IREAD) derr_d[gnt_cpu_q] = 1'b1;
                    end else begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (active) begin
            case (gnt_kind_q)
                DREAD: begin
                    ramREN  = 1'b1;
                    ramaddr = daddr[int'(gnt_cpu_q)*WORD_W +: WORD_W];
                end
                DWRITE: begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[int'(gnt_cpu_q)*WORD_W +: WORD_W];
                    ramstore = dstore[int'(gnt_cpu_q)*WORD_W +: WORD_W];
                end
                IREAD: begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr[int'(gnt_cpu_q)*WORD_W +: WORD_W];
                end
                default: ;
            endcase
        end
        if (done) begin
            if (gnt_kind_q == IREAD) begin
                iwait[gnt_cpu_q] = 1'b0;
                iload[int'(gnt_cpu_q)*WORD_W +: WORD_W] = ramload;
            end else begin
                dwait[gnt_cpu_q] = 1'b0;
                if (gnt_kind_q == DREAD) dload[int'(gnt_cpu_q)*WORD_W +: WORD_W] = ramload;
            end
        end
    end

    assign derr = derr_q;
endmodule
